// File: rtl/axi_wa_xbar.sv
// axi_wa_xbar: AXI write-address crossbar, NUM_M masters to NUM_S slaves.
//
// A round-robin arbiter grants one master in IDLE. Its address is decoded
// against per-slave base/mask pairs, and its payload is captured into a
// register slice that drives the shared slave bus. The channel stays locked
// until the W router reports the burst's last beat. The locked route is
// published for the W and B routers.
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   aw*_m, awvalid_m, awready_m  per-master AW channel (packed per master)
//   aw*_s, awvalid_s, awready_s  shared slave payload, per-slave valid/ready
//   w_last_done                  last W beat of the locked burst handshaked
//   route_valid/route_m/route_s  locked route (route_s == NUM_S is DECERR)
//
// awready_m is the only combinational output. The master handshake
// completes in the grant cycle.
//
// Build option: define AXI_WA_DECERR_EN to accept unmapped addresses as
// DECERR, with no slave AWVALID. Without it, unmapped addresses go to slave
// NUM_S-1.

module axi_wa_xbar #(
    parameter int unsigned NUM_M  = 2,
    parameter int unsigned NUM_S  = 6,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned SIZE_W = 3,
    parameter logic [NUM_S*ADDR_W-1:0] SLV_BASE = {
        32'h5000_0000, 32'h4000_0000, 32'h3000_0000,
        32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_S*ADDR_W-1:0] SLV_MASK = {
        32'hF000_0000, 32'hF000_0000, 32'hF000_0000,
        32'hF000_0000, 32'hF000_0000, 32'hF000_0000}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_M*ID_W-1:0]    awid_m,
    input  logic [NUM_M*ADDR_W-1:0]  awaddr_m,
    input  logic [NUM_M*LEN_W-1:0]   awlen_m,
    input  logic [NUM_M*SIZE_W-1:0]  awsize_m,
    input  logic [NUM_M*2-1:0]       awburst_m,
    input  logic [NUM_M-1:0]         awvalid_m,
    output logic [NUM_M-1:0]         awready_m,
    output logic [ID_W+3:0]          awid_s,
    output logic [ADDR_W-1:0]        awaddr_s,
    output logic [LEN_W-1:0]         awlen_s,
    output logic [SIZE_W-1:0]        awsize_s,
    output logic [1:0]               awburst_s,
    output logic [NUM_S-1:0]         awvalid_s,
    input  logic [NUM_S-1:0]         awready_s,
    input  logic                     w_last_done,
    output logic                     route_valid,
    output logic [3:0]               route_m,
    output logic [4:0]               route_s
);

    localparam int unsigned IDS_W = ID_W + 4;
    localparam int unsigned MI_W  = 4;
    localparam int unsigned SI_W  = 5;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    typedef struct packed {
        logic [IDS_W-1:0]  id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [SIZE_W-1:0] size;
        logic [1:0]        burst;
    } aw_t;

    state_t            state_q, state_d;
    logic [MI_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [MI_W-1:0]   gnt_q, gnt_d;
    logic [SI_W-1:0]   sel_q, sel_d;
    aw_t               aw_q, aw_d;
    logic [NUM_S-1:0]  awvalid_s_q, awvalid_s_d;
    logic              route_valid_q, route_valid_d;

    logic              gnt_vld;
    logic [MI_W-1:0]   gnt_idx;
    int unsigned       arb_dist;
    int unsigned       best_dist;

    logic [ID_W-1:0]   req_id;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [SIZE_W-1:0] req_size;
    logic [1:0]        req_burst;

    logic              dec_hit;
    logic [SI_W-1:0]   dec_sel;

    // Round-robin: the requester closest after rr_ptr (cyclically) wins.
    always_comb begin : arb
        gnt_vld   = 1'b0;
        gnt_idx   = '0;
        best_dist = NUM_M;
        arb_dist  = 0;
        for (int j = 0; j < NUM_M; j++) begin
            arb_dist = (unsigned'(j) + 2 * NUM_M - 32'(rr_ptr_q) - 1) % NUM_M;
            if (awvalid_m[j] && (arb_dist < best_dist)) begin
                best_dist = arb_dist;
                gnt_idx   = MI_W'(j);
                gnt_vld   = 1'b1;
            end
        end
    end

    // Select the granted master's payload.
    always_comb begin : req_mux
        req_id    = '0;
        req_addr  = '0;
        req_len   = '0;
        req_size  = '0;
        req_burst = '0;
        for (int j = 0; j < NUM_M; j++) begin
            if (gnt_idx == MI_W'(j)) begin
                req_id    = awid_m[j*ID_W +: ID_W];
                req_addr  = awaddr_m[j*ADDR_W +: ADDR_W];
                req_len   = awlen_m[j*LEN_W +: LEN_W];
                req_size  = awsize_m[j*SIZE_W +: SIZE_W];
                req_burst = awburst_m[j*2 +: 2];
            end
        end
    end

    // Address decode. Scan downward so the lowest matching slave is kept.
    always_comb begin : decode
        dec_hit = 1'b0;
        dec_sel = '0;
        for (int s = NUM_S - 1; s >= 0; s--) begin
            if ((req_addr & SLV_MASK[s*ADDR_W +: ADDR_W]) ==
                (SLV_BASE[s*ADDR_W +: ADDR_W] & SLV_MASK[s*ADDR_W +: ADDR_W])) begin
                dec_hit = 1'b1;
                dec_sel = SI_W'(s);
            end
        end
    end

    // Master ready is granted in IDLE only. It is masked by rst so the
    // output drops as soon as reset asserts.
    always_comb begin : master_ready
        awready_m = '0;
        if (!rst && (state_q == IDLE) && gnt_vld) begin
            awready_m = NUM_M'(1) << gnt_idx;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin : fsm_next
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        gnt_d         = gnt_q;
        sel_d         = sel_q;
        aw_d          = aw_q;
        awvalid_s_d   = awvalid_s_q;
        route_valid_d = route_valid_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    rr_ptr_d   = gnt_idx;
                    gnt_d      = gnt_idx;
                    aw_d.id    = {gnt_idx, req_id};
                    aw_d.addr  = req_addr;
                    aw_d.len   = req_len;
                    aw_d.size  = req_size;
                    aw_d.burst = req_burst;
                    if (dec_hit) begin
                        sel_d       = dec_sel;
                        awvalid_s_d = NUM_S'(1) << dec_sel;
                        state_d     = ADDR;
                    end else begin
`ifdef AXI_WA_DECERR_EN
                        sel_d         = SI_W'(NUM_S);
                        route_valid_d = 1'b1;
                        state_d       = DATA;
`else
                        sel_d       = SI_W'(NUM_S - 1);
                        awvalid_s_d = NUM_S'(1) << (NUM_S - 1);
                        state_d     = ADDR;
`endif
                    end
                end
            end
            ADDR: begin
                if (|(awvalid_s_q & awready_s)) begin
                    awvalid_s_d   = '0;
                    route_valid_d = 1'b1;
                    state_d       = DATA;
                end
            end
            DATA: begin
                if (w_last_done) begin
                    route_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= MI_W'(NUM_M - 1);
            gnt_q         <= '0;
            sel_q         <= '0;
            aw_q          <= '0;
            awvalid_s_q   <= '0;
            route_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            gnt_q         <= gnt_d;
            sel_q         <= sel_d;
            aw_q          <= aw_d;
            awvalid_s_q   <= awvalid_s_d;
            route_valid_q <= route_valid_d;
        end
    end

    assign awid_s      = aw_q.id;
    assign awaddr_s    = aw_q.addr;
    assign awlen_s     = aw_q.len;
    assign awsize_s    = aw_q.size;
    assign awburst_s   = aw_q.burst;
    assign awvalid_s   = awvalid_s_q;
    assign route_valid = route_valid_q;
    assign route_m     = gnt_q;
    assign route_s     = sel_q;

endmodule

// File: tb/tb_axi_wa_xbar.sv
// Testbench for axi_wa_xbar: random traffic from three masters against a
// transaction-level model. The driver keeps an abstract crossbar phase
// (idle / address / data) and pushes per-cycle control expectations and
// per-burst payload/route expectations. A negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_axi_wa_xbar;

    localparam int NM = 3;
    localparam int NS = 6;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int LW = 4;
    localparam int ZW = 3;
    localparam int NITER = 3000;

    // Slave 4 (0x34xx_xxxx) overlaps slave 3 (0x3xxx_xxxx); 0x4, 0x6-0xF are unmapped.
    localparam logic [NS*AW-1:0] BASE = {
        32'h5000_0000, 32'h3400_0000, 32'h3000_0000,
        32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NS*AW-1:0] MASK = {
        32'hF000_0000, 32'hFF00_0000, 32'hF000_0000,
        32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

    logic               clk = 1'b0;
    logic               rst;
    logic [NM*IW-1:0]   awid_m;
    logic [NM*AW-1:0]   awaddr_m;
    logic [NM*LW-1:0]   awlen_m;
    logic [NM*ZW-1:0]   awsize_m;
    logic [NM*2-1:0]    awburst_m;
    logic [NM-1:0]      awvalid_m;
    logic [NM-1:0]      awready_m;
    logic [IW+3:0]      awid_s;
    logic [AW-1:0]      awaddr_s;
    logic [LW-1:0]      awlen_s;
    logic [ZW-1:0]      awsize_s;
    logic [1:0]         awburst_s;
    logic [NS-1:0]      awvalid_s;
    logic [NS-1:0]      awready_s;
    logic               w_last_done;
    logic               route_valid;
    logic [3:0]         route_m;
    logic [4:0]         route_s;

    axi_wa_xbar #(
        .NUM_M(NM), .NUM_S(NS), .ADDR_W(AW), .ID_W(IW), .LEN_W(LW), .SIZE_W(ZW),
        .SLV_BASE(BASE), .SLV_MASK(MASK)
    ) dut (
        .clk(clk), .rst(rst),
        .awid_m(awid_m), .awaddr_m(awaddr_m), .awlen_m(awlen_m),
        .awsize_m(awsize_m), .awburst_m(awburst_m),
        .awvalid_m(awvalid_m), .awready_m(awready_m),
        .awid_s(awid_s), .awaddr_s(awaddr_s), .awlen_s(awlen_s),
        .awsize_s(awsize_s), .awburst_s(awburst_s),
        .awvalid_s(awvalid_s), .awready_s(awready_s),
        .w_last_done(w_last_done),
        .route_valid(route_valid), .route_m(route_m), .route_s(route_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NM-1:0] rdy_m;
        logic [NS-1:0] vld_s;
        logic          rv;
        logic          wld;
    } ctl_t;

    typedef struct {
        logic [IW+3:0] id;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [ZW-1:0] size;
        logic [1:0]    burst;
        int            m;
        int            s;
    } txn_t;

    ctl_t ctl_q[$];
    txn_t txn_q[$];
    ctl_t me;
    txn_t mt;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT outputs against the queued expectations.
    always @(negedge clk) begin
        if (!rst && ctl_q.size() > 0) begin
            me = ctl_q.pop_front();
            chk("awready_m", 64'(awready_m), 64'(me.rdy_m));
            chk("awvalid_s", 64'(awvalid_s), 64'(me.vld_s));
            chk("route_valid", 64'(route_valid), 64'(me.rv));
            if (me.vld_s != '0 || me.rv) begin
                if (txn_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL txn_queue actual=empty expected=entry at %0t", $time);
                end else begin
                    mt = txn_q[0];
                    chk("awid_s", 64'(awid_s), 64'(mt.id));
                    chk("awaddr_s", 64'(awaddr_s), 64'(mt.addr));
                    chk("awlen_s", 64'(awlen_s), 64'(mt.len));
                    chk("awsize_s", 64'(awsize_s), 64'(mt.size));
                    chk("awburst_s", 64'(awburst_s), 64'(mt.burst));
                    if (me.rv) begin
                        chk("route_m", 64'(route_m), 64'(mt.m));
                        chk("route_s", 64'(route_s), 64'(mt.s));
                        if (me.wld) void'(txn_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- behavioural model state ----------------
    logic [NM-1:0] r_v;
    logic [IW-1:0] r_id   [NM];
    logic [AW-1:0] r_addr [NM];
    logic [LW-1:0] r_len  [NM];
    logic [ZW-1:0] r_size [NM];
    logic [1:0]    r_bst  [NM];
    int phase;     // 0 idle, 1 address, 2 data
    int last;      // last granted master
    int cur_sel;
    int gnt_m;
    int wait_cnt;
    bit gnt_now;

    // Lowest-index slave whose masked base matches the address.
    function automatic int decode(input logic [AW-1:0] a);
        logic [AW-1:0] b;
        logic [AW-1:0] mk;
        for (int s = 0; s < NS; s++) begin
            b  = BASE[s*AW +: AW];
            mk = MASK[s*AW +: AW];
            if ((a & mk) == (b & mk)) return s;
        end
`ifdef AXI_WA_DECERR_EN
        return NS;
`else
        return NS - 1;
`endif
    endfunction

    task automatic new_req(input int m);
        int k;
        logic [3:0] nib;
        k = int'($urandom_range(0, 9));
        case (k)
            6:       nib = 4'h4;
            7:       nib = 4'hF;
            8:       nib = 4'h3;
            9:       nib = 4'h1;
            default: nib = 4'(k);
        endcase
        r_addr[m] = {nib, 28'($urandom)};
        if (k == 8) r_addr[m][27:24] = 4'h4;
        r_id[m]   = IW'($urandom);
        r_len[m]  = LW'($urandom);
        r_size[m] = ZW'($urandom);
        r_bst[m]  = 2'($urandom);
        r_v[m]    = 1'b1;
    endtask

    task automatic drive_masters();
        for (int m = 0; m < NM; m++) begin
            awid_m[m*IW +: IW]    = r_id[m];
            awaddr_m[m*AW +: AW]  = r_addr[m];
            awlen_m[m*LW +: LW]   = r_len[m];
            awsize_m[m*ZW +: ZW]  = r_size[m];
            awburst_m[m*2 +: 2]   = r_bst[m];
        end
        awvalid_m = r_v;
    endtask

    // Advance the abstract phase across the clock edge just taken.
    task automatic model_update();
        case (phase)
            0: if (gnt_now) begin
                last       = gnt_m;
                r_v[gnt_m] = 1'b0;
                phase      = (cur_sel == NS) ? 2 : 1;
                wait_cnt   = 0;
            end
            1: if (awready_s[cur_sel]) begin
                phase    = 2;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
            2: if (w_last_done) phase = 0;
            default: phase = 0;
        endcase
    endtask

    task automatic apply(input bit directed);
        if (!directed) begin
            for (int m = 0; m < NM; m++) begin
                if (r_v[m] && $urandom_range(0, 15) == 0) r_v[m] = 1'b0;
                else if (!r_v[m] && $urandom_range(0, 1) == 0) new_req(m);
            end
            awready_s = NS'($urandom);
            if (phase == 1) awready_s[cur_sel] = ($urandom_range(0, 2) == 0);
            w_last_done = (phase == 2) ? ($urandom_range(0, 2) == 0)
                                       : ($urandom_range(0, 7) == 0);
        end else begin
            awready_s   = (phase == 1 && wait_cnt >= 3) ? (NS'(1) << cur_sel) : '0;
            w_last_done = (phase == 2);
        end
        drive_masters();
    endtask

    // Predict this cycle's control outputs; queue a burst on a grant.
    task automatic expect_cycle();
        ctl_t e;
        txn_t t;
        int c;
        gnt_now = 1'b0;
        e.rdy_m = '0;
        if (phase == 0) begin
            for (int k = 1; k <= NM; k++) begin
                c = (last + k) % NM;
                if (!gnt_now && r_v[c]) begin
                    gnt_now = 1'b1;
                    gnt_m   = c;
                end
            end
            if (gnt_now) begin
                e.rdy_m = NM'(1) << gnt_m;
                cur_sel = decode(r_addr[gnt_m]);
                t.id    = {4'(gnt_m), r_id[gnt_m]};
                t.addr  = r_addr[gnt_m];
                t.len   = r_len[gnt_m];
                t.size  = r_size[gnt_m];
                t.burst = r_bst[gnt_m];
                t.m     = gnt_m;
                t.s     = cur_sel;
                txn_q.push_back(t);
            end
        end
        e.vld_s = (phase == 1) ? (NS'(1) << cur_sel) : '0;
        e.rv    = (phase == 2);
        e.wld   = (phase == 2) && w_last_done;
        ctl_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_awready_m"}, 64'(awready_m), 64'(0));
        chk({tag, "_awvalid_s"}, 64'(awvalid_s), 64'(0));
        chk({tag, "_route_valid"}, 64'(route_valid), 64'(0));
        chk({tag, "_route_m"}, 64'(route_m), 64'(0));
        chk({tag, "_route_s"}, 64'(route_s), 64'(0));
        chk({tag, "_awid_s"}, 64'(awid_s), 64'(0));
        chk({tag, "_awaddr_s"}, 64'(awaddr_s), 64'(0));
        chk({tag, "_awlen_s"}, 64'(awlen_s), 64'(0));
        chk({tag, "_awsize_s"}, 64'(awsize_s), 64'(0));
        chk({tag, "_awburst_s"}, 64'(awburst_s), 64'(0));
    endtask

    // Mid-burst reset: outputs must clear before the next edge; afterwards
    // all masters request and master 0 must win first.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero(tag);
        ctl_q.delete();
        txn_q.delete();
        for (int m = 0; m < NM; m++) if (!r_v[m]) new_req(m);
        awready_s   = '0;
        w_last_done = 1'b0;
        drive_masters();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        phase = 0;
        last  = NM - 1;
        expect_cycle();
    endtask

    initial begin
        bit did_addr_rst;
        bit did_data_rst;
        did_addr_rst = 1'b0;
        did_data_rst = 1'b0;
        rst         = 1'b1;
        r_v         = '0;
        awready_s   = '0;
        w_last_done = 1'b0;
        phase       = 0;
        last        = NM - 1;
        cur_sel     = 0;
        gnt_m       = 0;
        wait_cnt    = 0;
        gnt_now     = 1'b0;
        for (int m = 0; m < NM; m++) new_req(m);
        drive_masters();
        #1;
        check_all_zero("reset");
        r_v = '0;
        drive_masters();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed opener: master 1 to 0x1000_0004, slave 1 stalls 3 cycles.
        r_addr[1] = 32'h1000_0004;
        r_id[1]   = 4'hA;
        r_len[1]  = 4'h3;
        r_size[1] = 3'h2;
        r_bst[1]  = 2'b01;
        r_v[1]    = 1'b1;

        for (int it = 0; it < NITER; it++) begin
            if (it > 0) begin
                @(posedge clk);
                model_update();
                #1;
            end
            apply(it < 12);
            expect_cycle();
            if (it > 400 && !did_addr_rst && phase == 1) begin
                did_addr_rst = 1'b1;
                do_reset("rst_addr");
            end else if (it > 1200 && !did_data_rst && phase == 2) begin
                did_data_rst = 1'b1;
                do_reset("rst_data");
            end
        end
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
